// File: rtl/multiexp_dispatch_pkg.sv
// Shared types and helpers for the multiexp pair dispatcher.
package multiexp_dispatch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned NUM_CORES_DEF = 4;
    localparam int unsigned SCL_BITS_DEF  = 256;
    localparam int unsigned PNT_BITS_DEF  = 512;

    // Round-robin pointer width, never narrower than one bit.
    function automatic int unsigned rr_bits(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned RR_BITS = rr_bits(NUM_CORES_DEF);

    typedef struct packed {
        logic [SCL_BITS_DEF-1:0] scl;
        logic [PNT_BITS_DEF-1:0] pnt;
        logic                    last;
    } pair_t;

endpackage

// File: rtl/multiexp_pair_slot.sv
// Per-core registered (scalar, point, last) holder with AXI-stream load/hold/clear.
module multiexp_pair_slot #(
    parameter int unsigned SCL_BITS = 256,
    parameter int unsigned PNT_BITS = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                rdy,
    input  logic [SCL_BITS-1:0] ld_scl,
    input  logic [PNT_BITS-1:0] ld_pnt,
    input  logic                ld_last,
    output logic                val,
    output logic [SCL_BITS-1:0] scl,
    output logic [PNT_BITS-1:0] pnt,
    output logic                last
);

    // A load in the same cycle as a handshake overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val  <= 1'b0;
            scl  <= '0;
            pnt  <= '0;
            last <= 1'b0;
        end else if (load) begin
            val  <= 1'b1;
            scl  <= ld_scl;
            pnt  <= ld_pnt;
            last <= ld_last;
        end else if (rdy) begin
            val  <= 1'b0;
        end
    end

endmodule

// File: rtl/multiexp_pair_dispatcher.sv
// Joins scalar and point streams into pairs and deals them round-robin to NUM_CORES cores.
// Optional eop consistency checking is enabled by defining MULTIEXP_DISPATCH_EOP_CHECK_EN.
module multiexp_pair_dispatcher
    import multiexp_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned SCL_BITS  = 256,
    parameter int unsigned PNT_BITS  = 512,
    parameter int unsigned CNT_BITS  = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [CNT_BITS-1:0]           i_num_in,
    input  logic                          i_scl_val,
    output logic                          o_scl_rdy,
    input  logic [SCL_BITS-1:0]           i_scl_dat,
    input  logic                          i_scl_eop,
    input  logic                          i_pnt_val,
    output logic                          o_pnt_rdy,
    input  logic [PNT_BITS-1:0]           i_pnt_dat,
    input  logic                          i_pnt_eop,
    output logic [NUM_CORES-1:0]          o_core_val,
    input  logic [NUM_CORES-1:0]          i_core_rdy,
    output logic [NUM_CORES*SCL_BITS-1:0] o_core_scl,
    output logic [NUM_CORES*PNT_BITS-1:0] o_core_pnt,
    output logic [NUM_CORES-1:0]          o_core_last,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_err
);

    localparam int unsigned RrBits = rr_bits(NUM_CORES);
    localparam logic [CNT_BITS-1:0] CoresCnt = CNT_BITS'(NUM_CORES);
    localparam logic [RrBits-1:0] RrMax = RrBits'(NUM_CORES - 1);

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [CNT_BITS-1:0]   num_q, num_d;
    logic [RrBits-1:0]     rr_q, rr_d;
    logic                  start_ok;
    logic                  slot_free;
    logic                  accept;
    logic                  is_final;
    logic                  last_flag;
    logic [NUM_CORES-1:0]  load;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            num_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        rr_d      = rr_q;
        start_ok  = (state_q == StIdle) && i_start;
        slot_free = !o_core_val[rr_q] || i_core_rdy[rr_q];
        accept    = (state_q == StRun) && i_scl_val && i_pnt_val && slot_free;
        is_final  = (cnt_q == num_q - CNT_BITS'(1));
        // Short jobs mark every pair last; the guard avoids num_q - NUM_CORES underflowing.
        last_flag = (num_q <= CoresCnt) || (cnt_q >= num_q - CoresCnt);
        load      = accept ? (NUM_CORES'(1) << rr_q) : '0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    num_d   = i_num_in;
                    cnt_d   = '0;
                    rr_d    = '0;
                    state_d = (i_num_in == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                    rr_d  = (rr_q == RrMax) ? '0 : rr_q + RrBits'(1);
                    if (is_final) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (o_core_val == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_scl_rdy = accept;
    assign o_pnt_rdy = accept;
    assign o_busy    = (state_q != StIdle);
    assign o_done    = (state_q == StDone);

    for (genvar k = 0; k < NUM_CORES; k++) begin : gen_slot
        multiexp_pair_slot #(
            .SCL_BITS(SCL_BITS),
            .PNT_BITS(PNT_BITS)
        ) u_slot (
            .clk    (i_clk),
            .rst    (i_rst),
            .load   (load[k]),
            .rdy    (i_core_rdy[k]),
            .ld_scl (i_scl_dat),
            .ld_pnt (i_pnt_dat),
            .ld_last(last_flag),
            .val    (o_core_val[k]),
            .scl    (o_core_scl[k*SCL_BITS +: SCL_BITS]),
            .pnt    (o_core_pnt[k*PNT_BITS +: PNT_BITS]),
            .last   (o_core_last[k])
        );
    end

`ifdef MULTIEXP_DISPATCH_EOP_CHECK_EN
    logic err_q;

    // Both eops must mark exactly the final pair; a mismatch is flagged but dispatch carries on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end else if (accept && ((i_scl_eop != is_final) || (i_pnt_eop != is_final))) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    logic unused_eop;
    assign unused_eop = start_ok ^ i_scl_eop ^ i_pnt_eop;
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_multiexp_pair_dispatcher.sv
// Scoreboard bench for multiexp_pair_dispatcher: per-core expected-pair queues fed on accept.
module tb_multiexp_pair_dispatcher;
    import multiexp_dispatch_pkg::*;

    localparam int NC = 4;
    localparam int SB = 256;
    localparam int PB = 512;
    localparam int CB = 64;

`ifdef MULTIEXP_DISPATCH_EOP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [CB-1:0]    i_num_in;
    logic             i_scl_val, o_scl_rdy, i_scl_eop;
    logic [SB-1:0]    i_scl_dat;
    logic             i_pnt_val, o_pnt_rdy, i_pnt_eop;
    logic [PB-1:0]    i_pnt_dat;
    logic [NC-1:0]    o_core_val, i_core_rdy, o_core_last;
    logic [NC*SB-1:0] o_core_scl;
    logic [NC*PB-1:0] o_core_pnt;
    logic             o_busy, o_done, o_err;

    multiexp_pair_dispatcher #(
        .NUM_CORES(NC), .SCL_BITS(SB), .PNT_BITS(PB), .CNT_BITS(CB)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_in(i_num_in),
        .i_scl_val(i_scl_val), .o_scl_rdy(o_scl_rdy), .i_scl_dat(i_scl_dat),
        .i_scl_eop(i_scl_eop), .i_pnt_val(i_pnt_val), .o_pnt_rdy(o_pnt_rdy),
        .i_pnt_dat(i_pnt_dat), .i_pnt_eop(i_pnt_eop), .o_core_val(o_core_val),
        .i_core_rdy(i_core_rdy), .o_core_scl(o_core_scl), .o_core_pnt(o_core_pnt),
        .o_core_last(o_core_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int     n_tests = 0;
    int     n_fail  = 0;
    pair_t  exp_q [NC][$];
    bit     hold_v [NC];
    pair_t  hold_p [NC];
    longint s_idx, tot, bad_eop;
    int     rr_m, step_no, pnt_lag, stall_n, done_cnt, first_acc, last_acc;
    logic [NC-1:0] stall_mask, seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SB-1:0] mk_scl(input longint i);
        logic [SB-1:0] v;
        for (int j = 0; j < SB / 32; j++) v[j*32 +: 32] = 32'h5C00_0000 + 32'(i) * 32'd7 + 32'(j);
        return v;
    endfunction

    function automatic logic [PB-1:0] mk_pnt(input longint i);
        logic [PB-1:0] v;
        for (int j = 0; j < PB / 32; j++) v[j*32 +: 32] = 32'hB100_0000 ^ (32'(i) << 12) ^ 32'(j);
        return v;
    endfunction

    function automatic pair_t get_pair(input int k);
        pair_t p;
        p.scl  = o_core_scl[k*SB +: SB];
        p.pnt  = o_core_pnt[k*PB +: PB];
        p.last = o_core_last[k];
        return p;
    endfunction

    function automatic int q_total();
        int n = 0;
        for (int k = 0; k < NC; k++) n += exp_q[k].size();
        return n;
    endfunction

    // One cycle: drive at negedge, check combinational and registered outputs, advance.
    task automatic step();
        pair_t p, e;
        i_scl_val  = (s_idx < tot);
        i_pnt_val  = (s_idx < tot) && (step_no >= pnt_lag);
        i_scl_dat  = mk_scl(s_idx);
        i_pnt_dat  = mk_pnt(s_idx);
        i_scl_eop  = (s_idx == tot - 1) || (s_idx == bad_eop);
        i_pnt_eop  = (s_idx == tot - 1);
        i_core_rdy = (step_no < stall_n) ? ~stall_mask : '1;
        #1;
        check("rdy_pair", o_scl_rdy, o_pnt_rdy);
        for (int k = 0; k < NC; k++) begin
            p = get_pair(k);
            if (hold_v[k]) begin
                check("hold_val", o_core_val[k], 1);
                check("hold_data", p === hold_p[k], 1);
            end
            if (o_core_val[k]) seen[k] = 1'b1;
            if (o_core_val[k] && i_core_rdy[k]) begin
                if (exp_q[k].size() == 0) begin
                    check("extra_pair", 1, 0);
                end else begin
                    e = exp_q[k].pop_front();
                    check("pair_full", p === e, 1);
                    check("pair_scl", p.scl[63:0], e.scl[63:0]);
                    check("pair_last", p.last, e.last);
                end
            end
            hold_v[k] = o_core_val[k] && !i_core_rdy[k];
            hold_p[k] = p;
        end
        if (o_scl_rdy) begin
            check("acc_valid", i_scl_val && i_pnt_val, 1);
            check("acc_slot_busy", o_core_val[rr_m] && !i_core_rdy[rr_m], 0);
            e.scl  = mk_scl(s_idx);
            e.pnt  = mk_pnt(s_idx);
            e.last = (tot <= NC) || (s_idx >= tot - NC);
            exp_q[rr_m].push_back(e);
            rr_m = (rr_m + 1) % NC;
            s_idx++;
            if (first_acc < 0) first_acc = step_no;
            last_acc = step_no;
        end
        if (o_done) begin
            done_cnt++;
            check("done_busy", o_busy, 1);
            check("done_cores_idle", o_core_val, 0);
        end
        step_no++;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic start_job(input longint num, input int lag, input logic [NC-1:0] smask,
                             input int sn, input longint bad);
        tot = num; pnt_lag = lag; stall_mask = smask; stall_n = sn; bad_eop = bad;
        s_idx = 0; rr_m = 0; step_no = 0; done_cnt = 0; seen = '0;
        first_acc = -1; last_acc = -1;
        for (int k = 0; k < NC; k++) hold_v[k] = 1'b0;
        i_start = 1'b1;
        i_num_in = CB'(num);
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic run_job(input longint num, input int lag, input logic [NC-1:0] smask,
                           input int sn, input longint bad);
        start_job(num, lag, smask, sn, bad);
        for (int c = 0; c < 400 && !(done_cnt > 0 && q_total() == 0); c++) step();
        check("done_once", done_cnt, 1);
        check("dispatched", s_idx, num);
        check("queues_empty", q_total(), 0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_num_in = '0;
        i_scl_val = 1'b0; i_pnt_val = 1'b0; i_scl_dat = '0; i_pnt_dat = '0;
        i_scl_eop = 1'b0; i_pnt_eop = 1'b0; i_core_rdy = '1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // Reset state; streams offered while idle must not be popped.
        i_scl_val = 1'b1; i_pnt_val = 1'b1;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_val", o_core_val, 0);
        check("rst_err", o_err, 0);
        check("idle_scl_rdy", o_scl_rdy, 0);
        check("idle_pnt_rdy", o_pnt_rdy, 0);
        @(negedge i_clk);

        // Eight pairs, all ready: one pair per cycle, every core used, last on pairs 4..7.
        run_job(8, 0, '0, 0, -1);
        check("tput_span", last_acc - first_acc, 7);
        check("seen_8", seen, 4'hF);
        check("err_clean", o_err, 0);

        // Zero-length job: straight to DONE.
        start_job(0, 0, '0, 0, -1);
        check("zero_busy", o_busy, 1);
        check("zero_done", o_done, 1);
        check("zero_val", o_core_val, 0);
        @(negedge i_clk);
        check("zero_busy_after", o_busy, 0);
        check("zero_done_after", o_done, 0);

        // Two pairs: only cores 0 and 1 ever see data.
        run_job(2, 0, '0, 0, -1);
        check("seen_2", seen, 4'b0011);

        // Point stream lags by five cycles: nothing pops before both are valid.
        run_job(4, 5, '0, 0, -1);
        check("lag_first", first_acc, 5);

        // Core 2 stalled for ten cycles: pair 6 waits, later pairs follow it in order.
        run_job(12, 0, 4'b0100, 10, -1);
        check("stall_last_acc", last_acc, 15);
        check("stall_seen", seen, 4'hF);

        // Early scalar eop on pair 2, then a clean job clears the sticky flag.
        run_job(4, 0, '0, 0, 2);
        check("eop_err", o_err, EXP_ERR);
        run_job(1, 0, '0, 0, -1);
        check("eop_err_cleared", o_err, 0);

        // Reset in the middle of a run, after three pairs went out.
        start_job(8, 0, '0, 0, -1);
        for (int c = 0; c < 50 && s_idx < 3; c++) step();
        check("mid_cnt", s_idx, 3);
        i_rst = 1'b1;
        #1;
        check("mid_rst_val", o_core_val, 0);
        check("mid_rst_last", o_core_last, 0);
        check("mid_rst_scl", o_core_scl == '0, 1);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_rdy", o_scl_rdy, 0);
        for (int k = 0; k < NC; k++) exp_q[k].delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        run_job(4, 0, '0, 0, -1);
        check("post_rst_seen", seen, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multiexp_pair_dispatcher.md
Name: multiexp_pair_dispatcher

Overview:
- Joins the scalar stream (256b) and the affine point stream (512b) into (scalar, point) pairs.
- Distributes pairs round-robin across NUM_CORES parallel multiexp cores.
- Sits between the scalar/point AXI read masters and a bank of bn128 multiexp cores, replacing the single-core direct hookup.
- Tracks the element count, tags each core's final pair, and reports dispatch completion.

Parameters:
- NUM_CORES, 4, number of downstream multiexp cores (1..16).
- SCL_BITS, 256, scalar data width.
- PNT_BITS, 512, point data width (x||y).
- CNT_BITS, 64, width of element counter and i_num_in.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  single-cycle start pulse
- i_num_in  in  CNT_BITS  number of pairs; latched on accepted i_start
- i_scl_val  in  1  scalar stream valid
- o_scl_rdy  out  1  scalar stream ready
- i_scl_dat  in  SCL_BITS  scalar data
- i_scl_eop  in  1  scalar end-of-packet
- i_pnt_val  in  1  point stream valid
- o_pnt_rdy  out  1  point stream ready
- i_pnt_dat  in  PNT_BITS  point data
- i_pnt_eop  in  1  point end-of-packet
- o_core_val  out  NUM_CORES  per-core pair valid
- i_core_rdy  in  NUM_CORES  per-core ready
- o_core_scl  out  NUM_CORES*SCL_BITS  per-core scalar, core k at slice k
- o_core_pnt  out  NUM_CORES*PNT_BITS  per-core point
- o_core_last  out  NUM_CORES  final pair for that core
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle pulse when all pairs are taken by cores
- o_err  out  1  sticky eop mismatch flag (feature-dependent)

Behaviour:
- Reset is asynchronous: all outputs 0, state IDLE, counters 0, rr pointer 0.
- States:
  - IDLE: on i_start, latch num_in, cnt=0, rr=0. If num_in==0, go to DONE; else go to RUN.
  - RUN: a pair is accepted when i_scl_val & i_pnt_val & (~o_core_val[rr] | i_core_rdy[rr]). o_scl_rdy and o_pnt_rdy are both high only in that cycle, so both streams pop together. If only one stream is valid, neither pops.
  - On accept: core rr's output register loads scl/pnt; o_core_last[rr] = (cnt >= num_in - NUM_CORES), compared without underflow (true whenever num_in <= NUM_CORES). Then cnt++ and rr = (rr==NUM_CORES-1) ? 0 : rr+1.
  - RUN->DRAIN when the accepted pair has cnt==num_in-1.
  - DRAIN: wait until all o_core_val are 0, then go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- o_busy is high in RUN, DRAIN and DONE.
- Latency: a pair accepted at cycle t appears on o_core_val[rr] at t+1.
- Each core's output register holds data stable while val & ~rdy (AXI-stream rules). It clears on rdy unless reloaded in the same cycle, which gives full throughput of one pair/cycle.
- i_start outside IDLE is ignored. Stream data arriving in IDLE/DRAIN/DONE is not accepted (rdy=0).
- Counter does not wrap: num_in is up to 2^CNT_BITS-1; cnt compares with equality.
- Core k receives pairs k, k+NUM_CORES, k+2*NUM_CORES, ... in order.

Optional Feature:
- Macro MULTIEXP_DISPATCH_EOP_CHECK_EN.
- When defined:
  - On each accept, check that i_scl_eop and i_pnt_eop both equal (cnt==num_in-1).
  - On any mismatch, set o_err sticky; it clears only on reset or on the next accepted i_start.
  - Dispatch continues unchanged.
- When undefined: o_err is tied 0 and the eop inputs are unused.

Decomposition:
- Package multiexp_dispatch_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - localparam RR_BITS = $clog2(NUM_CORES) (minimum 1);
  - typedef pair_t struct {scl, pnt, last}.
- One sub-module, multiexp_pair_slot: the per-core registered output holder with load/hold/clear logic. It is instantiated NUM_CORES times via generate.

Test Plan:
- NUM_CORES=4, num_in=8, all cores ready, streams always valid -> core0 gets pairs 0,4; core1 gets 1,5; etc. Last asserted on pairs 4..7. o_done pulses 1 cycle after the last core takes pair 7. Sustains 1 pair/cycle.
- num_in=0 start -> o_busy high 1 cycle, o_done pulse next cycle, no o_core_val.
- num_in=2, NUM_CORES=4 -> cores 0,1 get one pair each with last=1; cores 2,3 never valid.
- Point stream lags scalar by 5 cycles -> no pops until both valid; o_scl_rdy==o_pnt_rdy every cycle.
- Core 2 rdy held low 10 cycles, num_in=12 -> core2 data stable while stalled; dispatch stops at rr==2; order preserved; done only after core2 drains.
- With EOP_CHECK_EN: num_in=4 and scalar eop asserted on pair 2 -> o_err=1 from pair 2 onward, still 4 pairs dispatched, o_err cleared on next start.
- Assert i_rst mid-RUN at cnt=3 -> all outputs 0 immediately; new start with num_in=4 dispatches from core 0.
